// File: rtl/qspi_target_if.sv
// QSPI pin bundle plus byte-wide memory port seen by the flash-emulating target.
// The slave modport is the target's view; master is the controller/memory side.
interface qspi_target_if #(
  parameter int ADDR_W = 16
);
  logic              qspi_sclk_i;
  logic              qspi_cs_ni;
  logic [3:0]        qspi_data_i;
  logic [3:0]        qspi_data_o;
  logic [3:0]        qspi_data_oen;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_rd_o;
  logic [7:0]        mem_rdata_i;
  logic              mem_wr_o;
  logic [7:0]        mem_wdata_o;
  logic              cmd_error_o;

  modport slave (
    input  qspi_sclk_i, qspi_cs_ni, qspi_data_i, mem_rdata_i,
    output qspi_data_o, qspi_data_oen, mem_addr_o, mem_rd_o,
           mem_wr_o, mem_wdata_o, cmd_error_o
  );

  modport master (
    output qspi_sclk_i, qspi_cs_ni, qspi_data_i, mem_rdata_i,
    input  qspi_data_o, qspi_data_oen, mem_addr_o, mem_rd_o,
           mem_wr_o, mem_wdata_o, cmd_error_o
  );
endinterface

// File: rtl/qspi_target.sv
// Mode-0 QSPI flash responder: oversamples the pins on clk_i and serves
// READ (03), QUAD OUTPUT READ (6B), PAGE PROGRAM (02) and READ STATUS (05)
// from a byte-wide memory port.
//
// state  | meaning
// IDLE   | waiting for cs_n to fall
// CMD    | shifting 8 opcode bits from IO0
// ADDR   | shifting 24 address bits from IO0
// DUMMY  | counting dummy clocks before quad data
// RDATA  | streaming memory bytes out (IO1 or IO[3:0])
// WDATA  | collecting bytes from IO0 and writing them
// STATUS | repeating STATUS_VAL on IO1
// IGNORE | unsupported opcode, wait for cs_n high
module qspi_target #(
  parameter int          ADDR_W     = 16,
  parameter int          DUMMY_CYC  = 8,
  parameter logic [7:0]  STATUS_VAL = 8'h00
) (
  input logic           clk_i,
  input logic           reset_i,
  qspi_target_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, STATUS, IGNORE} state_t;

  localparam logic [7:0] OP_RD   = 8'h03;
  localparam logic [7:0] OP_QRD  = 8'h6B;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYC - 1);

  state_t            state_q, state_d;
  logic [1:0]        sclk_s_q, cs_s_q, d0_s_q;
  logic              sclk_prev_q, cs_prev_q;
  logic [7:0]        op_q, cnt_q, sh_q, pf_q, wdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        data_q, oen_q, oen_d;
  logic              rd_q, rd_pend_q, wr_q, err_q;

  logic       sclk_s, cs_s, d0, rise, fall, cs_rise, cs_fall, quad;
  logic [7:0] op_shift, src;

  // Only IO0 is ever sampled as an input, so only that bit is synchronized.
  assign sclk_s   = sclk_s_q[1];
  assign cs_s     = cs_s_q[1];
  assign d0       = d0_s_q[1];
  assign rise     = sclk_s & ~sclk_prev_q & ~cs_s;
  assign fall     = ~sclk_s & sclk_prev_q & ~cs_s;
  assign cs_fall  = ~cs_s & cs_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;
  assign op_shift = {op_q[6:0], d0};
  assign quad     = (op_q == OP_QRD);
  assign src      = (state_q == STATUS) ? STATUS_VAL : pf_q;

  assign bus.qspi_data_o   = data_q;
  assign bus.qspi_data_oen = oen_q;
  assign bus.mem_addr_o    = addr_q;
  assign bus.mem_rd_o      = rd_q;
  assign bus.mem_wr_o      = wr_q;
  assign bus.mem_wdata_o   = wdata_q;
  assign bus.cmd_error_o   = err_q;

  // Two-flop synchronizers plus a delayed copy for edge detection.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sclk_s_q    <= 2'b00;
      cs_s_q      <= 2'b11;
      d0_s_q      <= 2'b00;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_s_q    <= {sclk_s_q[0], bus.qspi_sclk_i};
      cs_s_q      <= {cs_s_q[0], bus.qspi_cs_ni};
      d0_s_q      <= {d0_s_q[0], bus.qspi_data_i[0]};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state decode and output-enable for the state being entered.
  always_comb begin
    state_d = state_q;
    oen_d   = 4'hF;
    if (cs_rise) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  if (cs_fall) state_d = CMD;
        CMD:   if (rise && cnt_q == 8'd7) begin
                 if (op_shift == OP_RD || op_shift == OP_QRD || op_shift == OP_PP) state_d = ADDR;
                 else if (op_shift == OP_RDSR) state_d = STATUS;
                 else state_d = IGNORE;
               end
        ADDR:  if (rise && cnt_q == 8'd23) begin
                 if (op_q == OP_PP) state_d = WDATA;
                 else if (quad && DUMMY_CYC != 0) state_d = DUMMY;
                 else state_d = RDATA;
               end
        DUMMY: if (rise && cnt_q == DUMMY_LAST) state_d = RDATA;
        default: ;
      endcase
    end
    case (state_d)
      RDATA:   oen_d = quad ? 4'b0000 : 4'b1101;
      STATUS:  oen_d = 4'b1101;
      default: oen_d = 4'hF;
    endcase
  end

  // Shift registers, bit counter, address counter and memory strobes.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      op_q      <= '0;
      cnt_q     <= '0;
      sh_q      <= '0;
      pf_q      <= '0;
      wdata_q   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      oen_q     <= 4'hF;
      rd_q      <= 1'b0;
      rd_pend_q <= 1'b0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      rd_pend_q <= rd_q;
      oen_q     <= oen_d;
      if (wr_q) addr_q <= addr_q + ADDR_W'(1);
      // Prefetch return: only kept while the read phase continues.
      if (rd_pend_q && state_d == RDATA) begin
        pf_q   <= bus.mem_rdata_i;
        addr_q <= addr_q + ADDR_W'(1);
      end
      case (state_q)
        CMD: if (rise) begin
          op_q  <= op_shift;
          cnt_q <= cnt_q + 8'd1;
          if (cnt_q == 8'd7 && state_d == IGNORE) err_q <= 1'b1;
        end
        ADDR: if (rise) begin
          addr_q <= {addr_q[ADDR_W-2:0], d0};
          cnt_q  <= cnt_q + 8'd1;
        end
        DUMMY: if (rise) cnt_q <= cnt_q + 8'd1;
        WDATA: if (rise) begin
          sh_q  <= {sh_q[6:0], d0};
          cnt_q <= {5'd0, cnt_q[2:0] + 3'd1};
          if (cnt_q[2:0] == 3'd7) begin
            wr_q    <= 1'b1;
            wdata_q <= {sh_q[6:0], d0};
          end
        end
        RDATA, STATUS: if (fall) begin
          // A byte boundary loads the next byte and, for reads, starts the next prefetch.
          if (quad && state_q == RDATA) begin
            if (!cnt_q[0]) begin
              data_q <= src[7:4];
              sh_q   <= {src[3:0], 4'h0};
              rd_q   <= 1'b1;
            end else begin
              data_q <= sh_q[7:4];
            end
            cnt_q <= {7'd0, ~cnt_q[0]};
          end else begin
            if (cnt_q[2:0] == 3'd0) begin
              data_q <= {2'b00, src[7], 1'b0};
              sh_q   <= {src[6:0], 1'b0};
              if (state_q == RDATA) rd_q <= 1'b1;
            end else begin
              data_q <= {2'b00, sh_q[7], 1'b0};
              sh_q   <= {sh_q[6:0], 1'b0};
            end
            cnt_q <= {5'd0, cnt_q[2:0] + 3'd1};
          end
        end
        default: ;
      endcase
      if (state_d != state_q) begin
        cnt_q <= '0;
        if (state_d == RDATA) rd_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_qspi_target.sv
// Bench for qspi_target: a 16-bit-address and an 8-bit-address instance share
// the same QSPI stimulus; expected IO samples, memory writes and error pulses
// are queued by the stimulus and consumed by independent monitors.
module tb_qspi_target;
  localparam logic [7:0] STATUS_VAL = 8'h00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic [3:0] dio = 4'h0;

  always #5 clk = ~clk;

  qspi_target_if #(.ADDR_W(16)) if16 ();
  qspi_target_if #(.ADDR_W(8))  if8 ();

  assign if16.qspi_sclk_i = sclk;
  assign if16.qspi_cs_ni  = cs_n;
  assign if16.qspi_data_i = dio;
  assign if8.qspi_sclk_i  = sclk;
  assign if8.qspi_cs_ni   = cs_n;
  assign if8.qspi_data_i  = dio;

  qspi_target #(.ADDR_W(16), .DUMMY_CYC(8), .STATUS_VAL(STATUS_VAL)) u16 (
    .clk_i(clk), .reset_i(rst), .bus(if16.slave));
  qspi_target #(.ADDR_W(8), .DUMMY_CYC(8), .STATUS_VAL(STATUS_VAL)) u8 (
    .clk_i(clk), .reset_i(rst), .bus(if8.slave));

  logic [7:0] mem16 [0:65535];
  logic [7:0] mem8  [0:255];

  // Read-only memory models: data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (if16.mem_rd_o) if16.mem_rdata_i <= mem16[if16.mem_addr_o];
    if (if8.mem_rd_o)  if8.mem_rdata_i  <= mem8[if8.mem_addr_o];
  end

  typedef struct { logic [3:0] oen; logic [3:0] val; logic [3:0] mask; } io_exp_t;
  typedef struct { logic [15:0] addr; logic [7:0] data; } wr_exp_t;

  io_exp_t io_q[$];
  wr_exp_t wr16_q[$];
  wr_exp_t wr8_q[$];
  logic    err_q[$];
  io_exp_t e_io;
  wr_exp_t e_w16, e_w8;
  logic    e_err;
  int      total = 0;
  int      bad = 0;
  int      rd_cnt16 = 0;
  int      rd_before;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // IO monitor: whenever the target drives at the controller's sampling edge.
  always @(posedge sclk) begin
    if (if16.qspi_data_oen !== 4'hF) begin
      if (io_q.size() == 0) begin
        chk("io_unexpected_drive", 32'(if16.qspi_data_oen), 32'hF);
      end else begin
        e_io = io_q.pop_front();
        chk("io_oen", 32'(if16.qspi_data_oen), 32'(e_io.oen));
        chk("io_data", 32'(if16.qspi_data_o & e_io.mask), 32'(e_io.val));
      end
    end
  end

  // Memory-write and error-pulse monitor.
  always @(negedge clk) begin
    if (if16.mem_rd_o === 1'b1) rd_cnt16++;
    if (if16.mem_wr_o === 1'b1) begin
      if (wr16_q.size() == 0) chk("wr16_unexpected", 32'(if16.mem_wr_o), 32'd0);
      else begin
        e_w16 = wr16_q.pop_front();
        chk("wr16_addr", 32'(if16.mem_addr_o), 32'(e_w16.addr));
        chk("wr16_data", 32'(if16.mem_wdata_o), 32'(e_w16.data));
      end
    end
    if (if8.mem_wr_o === 1'b1) begin
      if (wr8_q.size() == 0) chk("wr8_unexpected", 32'(if8.mem_wr_o), 32'd0);
      else begin
        e_w8 = wr8_q.pop_front();
        chk("wr8_addr", 32'(if8.mem_addr_o), 32'(e_w8.addr));
        chk("wr8_data", 32'(if8.mem_wdata_o), 32'(e_w8.data));
      end
    end
    if (if16.cmd_error_o === 1'b1) begin
      if (err_q.size() == 0) chk("cmd_error_unexpected", 32'(if16.cmd_error_o), 32'd0);
      else e_err = err_q.pop_front();
    end
  end

  task automatic clk_bit(input logic b);
    dio[0] = b;
    repeat (8) @(negedge clk);
    sclk = 1'b1;
    repeat (8) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) clk_bit(b[i]);
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 23; i >= 0; i--) clk_bit(a[i]);
  endtask

  task automatic idle_clocks(input int n);
    for (int i = 0; i < n; i++) clk_bit(1'b0);
  endtask

  task automatic cs_begin();
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (8) @(negedge clk);
    cs_n = 1'b1;
    repeat (24) @(negedge clk);
  endtask

  task automatic exp_single(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) io_q.push_back('{4'b1101, {2'b00, b[i], 1'b0}, 4'b0010});
  endtask

  task automatic exp_quad(input logic [7:0] b);
    io_q.push_back('{4'b0000, b[7:4], 4'hF});
    io_q.push_back('{4'b0000, b[3:0], 4'hF});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_oen"},   32'(if16.qspi_data_oen), 32'hF);
    chk({tag, "_data"},  32'(if16.qspi_data_o), 32'h0);
    chk({tag, "_addr"},  32'(if16.mem_addr_o), 32'h0);
    chk({tag, "_rd"},    32'(if16.mem_rd_o), 32'h0);
    chk({tag, "_wr"},    32'(if16.mem_wr_o), 32'h0);
    chk({tag, "_wdata"}, 32'(if16.mem_wdata_o), 32'h0);
    chk({tag, "_err"},   32'(if16.cmd_error_o), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem16[i] = 8'h00;
    for (int i = 0; i < 256; i++) mem8[i] = 8'h00;
    mem16[16'h0000] = 8'h5A;
    mem16[16'h0010] = 8'hA5;
    mem16[16'h0011] = 8'h3C;
    mem16[16'h0020] = 8'h12;
    mem16[16'h0021] = 8'h34;

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single read at 0x10.
    exp_single(8'hA5);
    exp_single(8'h3C);
    cs_begin();
    send_byte(8'h03);
    send_addr(24'h000010);
    idle_clocks(16);
    cs_end();
    chk("oen_after_read", 32'(if16.qspi_data_oen), 32'hF);

    // Quad output read at 0x20.
    exp_quad(8'h12);
    exp_quad(8'h34);
    cs_begin();
    send_byte(8'h6B);
    send_addr(24'h000020);
    idle_clocks(8);
    idle_clocks(4);
    cs_end();
    chk("oen_after_quad", 32'(if16.qspi_data_oen), 32'hF);

    // Page program crossing the address wrap.
    wr16_q.push_back('{16'h00FE, 8'h11});
    wr16_q.push_back('{16'h00FF, 8'h22});
    wr16_q.push_back('{16'h0100, 8'h33});
    wr8_q.push_back('{16'h00FE, 8'h11});
    wr8_q.push_back('{16'h00FF, 8'h22});
    wr8_q.push_back('{16'h0000, 8'h33});
    cs_begin();
    send_byte(8'h02);
    send_addr(24'h0000FE);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    cs_end();
    chk("wr16_pending", 32'(wr16_q.size()), 32'd0);
    chk("wr8_pending", 32'(wr8_q.size()), 32'd0);

    // Unsupported opcode, then status read.
    rd_before = rd_cnt16;
    err_q.push_back(1'b1);
    cs_begin();
    send_byte(8'h9F);
    idle_clocks(8);
    cs_end();
    chk("err_pending", 32'(err_q.size()), 32'd0);
    chk("rd_during_ignore", 32'(rd_cnt16 - rd_before), 32'd0);
    exp_single(STATUS_VAL);
    exp_single(STATUS_VAL);
    cs_begin();
    send_byte(8'h05);
    idle_clocks(16);
    cs_end();

    // Aborted write followed by a normal read at 0.
    cs_begin();
    send_byte(8'h02);
    send_addr(24'h000000);
    clk_bit(1'b1);
    clk_bit(1'b0);
    clk_bit(1'b1);
    clk_bit(1'b0);
    cs_end();
    exp_single(8'h5A);
    cs_begin();
    send_byte(8'h03);
    send_addr(24'h000000);
    idle_clocks(8);
    cs_end();

    // Reset in the middle of a quad data phase.
    exp_quad(8'h12);
    cs_begin();
    send_byte(8'h6B);
    send_addr(24'h000020);
    idle_clocks(8);
    idle_clocks(2);
    repeat (6) @(negedge clk);
    chk("oen_quad_before_reset", 32'(if16.qspi_data_oen), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("midreset");
    cs_end();
    exp_single(8'h3C);
    cs_begin();
    send_byte(8'h03);
    send_addr(24'h000011);
    idle_clocks(8);
    cs_end();

    chk("io_pending", 32'(io_q.size()), 32'd0);
    chk("wr16_left", 32'(wr16_q.size()), 32'd0);
    chk("wr8_left", 32'(wr8_q.size()), 32'd0);
    chk("err_left", 32'(err_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
